// File: rtl/truth_table_sweeper.sv
// Stimulus/capture stage for a combinational truth-table block: drives every input row, waits a settle
// window, packs the sampled outputs into a table and compares it against a golden table latched at start.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int N_OUT         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [(2**N_IN)*N_OUT-1:0] expected,
    output logic [N_IN-1:0]            in_vec,
    input  logic [N_OUT-1:0]           out_vec,
    output logic                       busy,
    output logic                       done,
    output logic [(2**N_IN)*N_OUT-1:0] table_out,
    output logic                       table_valid,
    output logic                       pass,
    output logic [N_IN-1:0]            fail_row
);
    localparam int ROWS  = 2**N_IN;
    localparam int TW    = ROWS*N_OUT;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  ROW_LAST = N_IN'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic [N_IN-1:0]   r_in_vec;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [TW-1:0]     r_table;
    logic              r_table_valid;
    logic              r_pass;
    logic [N_IN-1:0]   r_fail_row;
    logic              r_fail_seen;
    logic [TW-1:0]     r_expected;

    logic [N_OUT-1:0]  w_exp_slice;
    logic              w_sample;
    logic              w_last_row;
    logic              w_row_mismatch;

    // Row-level decode: golden slice for the current row, sampling edge and last-row detection.
    always_comb begin
        w_exp_slice    = r_expected[int'(r_in_vec)*N_OUT +: N_OUT];
        w_sample       = (r_cnt == CNT_LAST);
        w_last_row     = (r_in_vec == ROW_LAST);
        w_row_mismatch = (out_vec != w_exp_slice);
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_in_vec      <= {N_IN{1'b0}};
            r_cnt         <= {CNT_W{1'b0}};
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_table       <= {TW{1'b0}};
            r_table_valid <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_row    <= {N_IN{1'b0}};
            r_fail_seen   <= 1'b0;
            r_expected    <= {TW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy        <= 1'b1;
                        r_in_vec      <= {N_IN{1'b0}};
                        r_cnt         <= {CNT_W{1'b0}};
                        r_table_valid <= 1'b0;
                        r_pass        <= 1'b0;
                        r_fail_row    <= {N_IN{1'b0}};
                        r_fail_seen   <= 1'b0;
                        r_expected    <= expected;
                        r_table       <= {TW{1'b0}};
                        r_state       <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (w_sample) begin
                        r_cnt <= {CNT_W{1'b0}};
                        r_table[int'(r_in_vec)*N_OUT +: N_OUT] <= out_vec;
                        // Only the first mismatch is reported; later rows never overwrite it.
                        if (w_row_mismatch && !r_fail_seen) begin
                            r_fail_row  <= r_in_vec;
                            r_fail_seen <= 1'b1;
                        end
                        if (w_last_row) begin
                            r_in_vec <= {N_IN{1'b0}};
                            r_state  <= ST_FINISH;
                        end else begin
                            r_in_vec <= r_in_vec + N_IN'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    r_done        <= 1'b1;
                    r_table_valid <= 1'b1;
                    r_busy        <= 1'b0;
                    r_pass        <= ~r_fail_seen;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_vec      = r_in_vec;
    assign busy        = r_busy;
    assign done        = r_done;
    assign table_out   = r_table;
    assign table_valid = r_table_valid;
    assign pass        = r_pass;
    assign fail_row    = r_fail_row;

endmodule
